branch_predictor: RTL and testbench

Parametrised branch target buffer with 2-bit saturating direction counters for the pipelined RISC-V core. In IF it looks up `current_pc` and returns a predicted next PC in the same cycle. In MEM it is trained with the resolved branch outcome, and it flags mispredictions so the core can flush IF/ID/EX. It also keeps saturating branch and misprediction counters for performance analysis.

---
 rtl/branch_predictor.sv | 142 ++++++++++++++
 tb/tb_branch_predictor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Same-cycle lookup for IF, training and misprediction detection from MEM.

module bp_entry #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              en,
  input  logic              flush,
  input  logic              sel,
  input  logic              upd_taken,
  input  logic [TAG_W-1:0]  upd_tag,
  input  logic [DATA_W-1:0] upd_target,
  output logic              valid,
  output logic [TAG_W-1:0]  tag,
  output logic [DATA_W-1:0] target,
  output logic              ctr_msb
);
  logic [1:0] ctr;
  logic       hit;

  assign hit     = valid && (tag == upd_tag);
  assign ctr_msb = ctr[1];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid  <= 1'b0;
      tag    <= '0;
      target <= '0;
      ctr    <= 2'b01;
    end else if (en) begin
      if (flush) begin
        // only validity is dropped; stale target/ctr are harmless once invalid
        valid <= 1'b0;
      end else if (sel) begin
        if (hit) begin
          if (upd_taken) begin
            if (ctr != 2'b11) ctr <= ctr + 2'b01;
            target <= upd_target;
          end else if (ctr != 2'b00) begin
            ctr <= ctr - 2'b01;
          end
        end else if (upd_taken) begin
          valid  <= 1'b1;
          tag    <= upd_tag;
          target <= upd_target;
          ctr    <= 2'b10;
        end
      end
    end
  end
endmodule

module branch_predictor #(
  parameter int DATA_W  = 64,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              flush_table,
  input  logic [DATA_W-1:0] lookup_pc,
  output logic              pred_taken,
  output logic [DATA_W-1:0] pred_pc,
  input  logic              upd_valid,
  input  logic [DATA_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [DATA_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [DATA_W-1:0] upd_pred_pc,
  output logic              mispredict,
  output logic [DATA_W-1:0] correct_pc,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispredict_cnt
);
  localparam int IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic              valid;
    logic              taken;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] target;
  } upd_req_t;

  upd_req_t                        req;
  logic [IDX_W-1:0]                l_idx;
  logic [TAG_W-1:0]                l_tag;
  logic                            l_hit;
  logic [ENTRIES-1:0]              e_valid;
  logic [ENTRIES-1:0]              e_ctr_msb;
  logic [ENTRIES-1:0][TAG_W-1:0]   e_tag;
  logic [ENTRIES-1:0][DATA_W-1:0]  e_target;

  assign req.valid  = upd_valid;
  assign req.taken  = upd_taken;
  assign req.idx    = upd_pc[IDX_W+1:2];
  assign req.tag    = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign req.target = upd_target;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    bp_entry #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_entry (
      .clk        (clk),
      .arst_n     (arst_n),
      .en         (enable),
      .flush      (flush_table),
      .sel        (req.valid && (req.idx == IDX_W'(i))),
      .upd_taken  (req.taken),
      .upd_tag    (req.tag),
      .upd_target (req.target),
      .valid      (e_valid[i]),
      .tag        (e_tag[i]),
      .target     (e_target[i]),
      .ctr_msb    (e_ctr_msb[i])
    );
  end

  // lookup reads registered state, so a same-cycle update is not visible yet
  assign l_idx      = lookup_pc[IDX_W+1:2];
  assign l_tag      = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign l_hit      = e_valid[l_idx] && (e_tag[l_idx] == l_tag);
  assign pred_taken = l_hit && e_ctr_msb[l_idx];
  assign pred_pc    = pred_taken ? e_target[l_idx] : lookup_pc + DATA_W'(4);

  assign correct_pc = upd_taken ? upd_target : upd_pc + DATA_W'(4);
  assign mispredict = upd_valid &&
                      ((upd_pred_taken != upd_taken) || (upd_pred_pc != correct_pc));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (enable && upd_valid) begin
      if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
      if (mispredict && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector table, reset/saturation sequences and a randomized run
// compared against an array-based behavioural model of the predictor.

module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        arst_n;
  logic        enable, flush_table, upd_valid, upd_taken, upd_pred_taken;
  logic [63:0] lookup_pc, upd_pc, upd_target, upd_pred_pc;
  logic        pred_taken, mispredict, pred_taken4, mispredict4;
  logic [63:0] pred_pc, correct_pc, pred_pc4, correct_pc4;
  logic [31:0] branch_cnt, mispredict_cnt;
  logic [3:0]  branch_cnt4, mispredict_cnt4;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .flush_table(flush_table),
    .lookup_pc(lookup_pc), .pred_taken(pred_taken), .pred_pc(pred_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_pc(upd_pred_pc),
    .mispredict(mispredict), .correct_pc(correct_pc),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  branch_predictor #(.CNT_W(4)) dut4 (
    .clk(clk), .arst_n(arst_n), .enable(enable), .flush_table(flush_table),
    .lookup_pc(lookup_pc), .pred_taken(pred_taken4), .pred_pc(pred_pc4),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_pc(upd_pred_pc),
    .mispredict(mispredict4), .correct_pc(correct_pc4),
    .branch_cnt(branch_cnt4), .mispredict_cnt(mispredict_cnt4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid[16];
  int          m_tag[16];
  logic [63:0] m_tgt[16];
  int          m_ctr[16];
  longint      m_bc, m_mc, m_bc4, m_mc4;

  function automatic void m_reset();
    for (int k = 0; k < 16; k++) begin
      m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = '0; m_ctr[k] = 1;
    end
    m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
  endfunction

  function automatic void m_pred(input logic [63:0] pc, output bit t, output logic [63:0] npc);
    int i  = int'((pc >> 2) % 16);
    int tg = int'((pc >> 6) % 256);
    t   = m_valid[i] && (m_tag[i] == tg) && (m_ctr[i] >= 2);
    npc = t ? m_tgt[i] : pc + 64'd4;
  endfunction

  function automatic logic [63:0] m_cpc();
    return upd_taken ? upd_target : upd_pc + 64'd4;
  endfunction

  function automatic bit m_mp();
    return upd_valid && ((upd_pred_taken != upd_taken) || (upd_pred_pc != m_cpc()));
  endfunction

  function automatic void m_edge();
    int i, tg;
    bit mp;
    if (enable) begin
      mp = m_mp();
      if (upd_valid) begin
        if (m_bc < 64'hFFFF_FFFF) m_bc++;
        if (m_bc4 < 15) m_bc4++;
        if (mp && m_mc < 64'hFFFF_FFFF) m_mc++;
        if (mp && m_mc4 < 15) m_mc4++;
      end
      if (flush_table) begin
        for (int k = 0; k < 16; k++) m_valid[k] = 0;
      end else if (upd_valid) begin
        i  = int'((upd_pc >> 2) % 16);
        tg = int'((upd_pc >> 6) % 256);
        if (m_valid[i] && m_tag[i] == tg) begin
          if (upd_taken) begin
            m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            m_tgt[i] = upd_target;
          end else begin
            m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
          end
        end else if (upd_taken) begin
          m_valid[i] = 1; m_tag[i] = tg; m_tgt[i] = upd_target; m_ctr[i] = 2;
        end
      end
    end
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          en, fl, uv;
    logic [63:0] upc;
    bit          ut;
    logic [63:0] utgt;
    bit          upt;
    logic [63:0] uppc, lpc;
    bit          ept;
    logic [63:0] eppc;
    bit          emp;
    logic [63:0] ecpc;
    int          ebc, emc;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(bit en, bit fl, bit uv, logic [63:0] upc, bit ut, logic [63:0] utgt,
                              bit upt, logic [63:0] uppc, logic [63:0] lpc, bit ept,
                              logic [63:0] eppc, bit emp, logic [63:0] ecpc, int ebc, int emc);
    vec_t v;
    v.en = en; v.fl = fl; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.upt = upt; v.uppc = uppc; v.lpc = lpc; v.ept = ept; v.eppc = eppc;
    v.emp = emp; v.ecpc = ecpc; v.ebc = ebc; v.emc = emc;
    return v;
  endfunction

  task automatic apply(input bit en, input bit fl, input bit uv, input logic [63:0] upc,
                       input bit ut, input logic [63:0] utgt, input bit upt,
                       input logic [63:0] uppc, input logic [63:0] lpc);
    enable = en; flush_table = fl; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_pred_taken = upt; upd_pred_pc = uppc; lookup_pc = lpc;
  endtask

  initial begin
    bit          t;
    logic [63:0] npc, r;

    arst_n = 1'b0;
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    m_reset();
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    #2;
    chk("reset_branch_cnt", branch_cnt, 0);
    chk("reset_mispredict_cnt", mispredict_cnt, 0);

    tbl[0]  = mk(1,0,0,0,0,0,0,0,'h100,            0,'h104,0,'h4,0,0);
    tbl[1]  = mk(1,0,1,'h100,1,'h200,0,'h104,'h100, 0,'h104,1,'h200,0,0);
    tbl[2]  = mk(1,0,1,'h100,1,'h200,1,'h200,'h100, 1,'h200,0,'h200,1,1);
    tbl[3]  = mk(1,0,1,'h100,1,'h200,1,'h200,'h100, 1,'h200,0,'h200,2,1);
    tbl[4]  = mk(1,0,1,'h100,1,'h200,1,'h200,'h100, 1,'h200,0,'h200,3,1);
    tbl[5]  = mk(1,0,1,'h100,0,'h200,1,'h200,'h100, 1,'h200,1,'h104,4,1);
    tbl[6]  = mk(1,0,1,'h100,0,'h200,1,'h200,'h100, 1,'h200,1,'h104,5,2);
    tbl[7]  = mk(1,0,1,'h100,0,'h200,0,'h104,'h100, 0,'h104,0,'h104,6,3);
    tbl[8]  = mk(1,0,1,'h100,0,'h200,0,'h104,'h100, 0,'h104,0,'h104,7,3);
    tbl[9]  = mk(1,0,1,'h100,1,'h200,0,'h104,'h100, 0,'h104,1,'h200,8,3);
    tbl[10] = mk(1,0,1,'h100,1,'h200,0,'h104,'h100, 0,'h104,1,'h200,9,4);
    tbl[11] = mk(1,0,1,'h140,1,'h300,0,'h144,'h100, 1,'h200,1,'h300,10,5);
    tbl[12] = mk(1,0,0,0,0,0,0,0,'h100,            0,'h104,0,'h4,11,6);
    tbl[13] = mk(1,1,1,'h100,1,'h200,0,'h104,'h140, 1,'h300,1,'h200,11,6);
    tbl[14] = mk(0,0,1,'h140,1,'h300,0,'h144,'h140, 0,'h144,1,'h300,12,7);
    tbl[15] = mk(1,0,0,0,0,0,0,0,'h140,            0,'h144,0,'h4,12,7);
    tbl[16] = mk(1,0,0,0,0,0,0,0,'h100,            0,'h104,0,'h4,12,7);

    for (int n = 0; n < 17; n++) begin
      apply(tbl[n].en, tbl[n].fl, tbl[n].uv, tbl[n].upc, tbl[n].ut, tbl[n].utgt,
            tbl[n].upt, tbl[n].uppc, tbl[n].lpc);
      #2;
      chk($sformatf("vec%0d_pred_taken", n), pred_taken, tbl[n].ept);
      chk($sformatf("vec%0d_pred_pc", n), pred_pc, tbl[n].eppc);
      chk($sformatf("vec%0d_mispredict", n), mispredict, tbl[n].emp);
      chk($sformatf("vec%0d_correct_pc", n), correct_pc, tbl[n].ecpc);
      chk($sformatf("vec%0d_branch_cnt", n), branch_cnt, tbl[n].ebc);
      chk($sformatf("vec%0d_mispredict_cnt", n), mispredict_cnt, tbl[n].emc);
      @(negedge clk);
    end

    // 20 mispredicting not-taken branches: narrow counters pin at 15
    for (int n = 0; n < 20; n++) begin
      apply(1, 0, 1, 'h400, 0, 0, 1, 0, 'h100);
      @(negedge clk);
    end
    apply(1, 0, 0, 0, 0, 0, 0, 0, 'h100);
    #2;
    chk("sat_branch_cnt4", branch_cnt4, 15);
    chk("sat_mispredict_cnt4", mispredict_cnt4, 15);
    chk("sat_branch_cnt", branch_cnt, 32);
    chk("sat_mispredict_cnt", mispredict_cnt, 27);
    @(negedge clk);

    // allocate 0x100, then reset mid-cycle with another update pending
    apply(1, 0, 1, 'h100, 1, 'h200, 0, 'h104, 'h100);
    @(negedge clk);
    #2;
    chk("pre_rst_pred_taken", pred_taken, 1);
    #1 arst_n = 1'b0;
    #1;
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_pred_pc", pred_pc, 'h104);
    chk("rst_branch_cnt", branch_cnt, 0);
    chk("rst_mispredict_cnt", mispredict_cnt, 0);
    chk("rst_mispredict_cnt4", mispredict_cnt4, 0);
    @(negedge clk);
    arst_n = 1'b1;
    apply(1, 0, 0, 0, 0, 0, 0, 0, 'h100);
    #2;
    chk("post_rst_pred_taken", pred_taken, 0);
    chk("post_rst_branch_cnt", branch_cnt, 0);
    m_reset();
    @(negedge clk);

    // randomized run against the model
    for (int n = 0; n < 600; n++) begin
      enable      = ($urandom_range(0, 9) != 0);
      flush_table = ($urandom_range(0, 39) == 0);
      upd_valid   = ($urandom_range(0, 3) != 0);
      upd_pc      = 64'($urandom_range(0, 255)) << 2;
      upd_taken   = $urandom_range(0, 1) != 0;
      upd_target  = $urandom_range(0, 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 63)) << 4;
      lookup_pc   = $urandom_range(0, 2) == 0 ? upd_pc : 64'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 1)) begin
        m_pred(upd_pc, t, npc);
        upd_pred_taken = t; upd_pred_pc = npc;
      end else begin
        upd_pred_taken = $urandom_range(0, 1) != 0;
        r = upd_pred_taken ? upd_target : upd_pc + 64'd4;
        upd_pred_pc = $urandom_range(0, 3) == 0 ? {$urandom, $urandom} : r;
      end
      #2;
      m_pred(lookup_pc, t, npc);
      chk("rnd_pred_taken", pred_taken, t);
      chk("rnd_pred_pc", pred_pc, npc);
      chk("rnd_pred_pc4", pred_pc4, npc);
      chk("rnd_mispredict", mispredict, m_mp());
      chk("rnd_correct_pc", correct_pc, m_cpc());
      chk("rnd_branch_cnt", branch_cnt, m_bc);
      chk("rnd_mispredict_cnt", mispredict_cnt, m_mc);
      chk("rnd_branch_cnt4", branch_cnt4, m_bc4);
      chk("rnd_mispredict_cnt4", mispredict_cnt4, m_mc4);
      @(posedge clk);
      m_edge();
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
